// File: rtl/motor_pwm_driver_pkg.sv
// ============================================================================
// Module      : rover_pwm_pkg
// Description : Shared constants and types for the rover motor PWM driver.
//               CW_DEFAULT    - default counter/duty width (matches counter)
//               PERIOD_20KHZ  - counterPeriod for 20 kHz PWM at 100 MHz clock
//               PERIOD_1KHZ   - counterPeriod for 1 kHz PWM at 100 MHz clock
//               state_t       - driver FSM encoding (STOP/RUN/DEAD)
// Options     : none (SOFT_START_EN is consumed by pwm_duty_shadow)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package rover_pwm_pkg;

  localparam int          CW_DEFAULT   = 28;
  localparam logic [27:0] PERIOD_20KHZ = 28'd5000;
  localparam logic [27:0] PERIOD_1KHZ  = 28'd100000;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/motor_pwm_driver_if.sv
// ============================================================================
// Module      : motor_pwm_driver_if
// Description : Duty-request handshake between a duty source and the driver.
//               duty       - requested high-time in clocks (CW bits)
//               duty_valid - source has a duty request present
//               duty_ready - driver's pending-duty slot is empty
//               Transfer happens on a clock where duty_valid && duty_ready.
//               master : duty source    slave : motor_pwm_driver
// Options     : none
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface motor_pwm_driver_if
  import rover_pwm_pkg::*;
#(
  parameter int CW = CW_DEFAULT
);

  logic [CW-1:0] duty;
  logic          duty_valid;
  logic          duty_ready;

  modport master (output duty, output duty_valid, input duty_ready);
  modport slave  (input duty, input duty_valid, output duty_ready);

endinterface

`default_nettype wire

// File: rtl/motor_pwm_driver_duty_shadow.sv
// ============================================================================
// Module      : pwm_duty_shadow
// Description : Pending/active duty registers for the motor PWM driver.
//               A request is captured into the pending slot by handshake and
//               only becomes the active duty at a period boundary, so the
//               PWM waveform never changes shape mid-period.
// Ports       : clock, reset  - system clock, synchronous active-high reset
//               i_boundary    - high on the last count of a period
//               i_run         - driver FSM is in RUN
//               duty_if       - duty handshake (slave side)
//               o_active      - duty used by the PWM compare
// Options     : SOFT_START_EN - when defined, active ramps up toward the last
//               loaded duty by RAMP_STEP per boundary while running, drops to
//               a lower target immediately, and is cleared whenever the driver
//               is not in RUN. When undefined, RAMP_STEP and i_run are unused.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pwm_duty_shadow
  import rover_pwm_pkg::*;
#(
  parameter int CW        = CW_DEFAULT,
  parameter int RAMP_STEP = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_boundary,
  input  logic              i_run,
  motor_pwm_driver_if.slave duty_if,
  output logic [CW-1:0]     o_active
);

  logic [CW-1:0] r_pending;
  logic          r_pend_full;
  logic [CW-1:0] r_active;
  logic          w_accept;
  logic          w_load;

  // The slot is a single entry, so "ready" is exactly "slot empty".
  assign duty_if.duty_ready = ~r_pend_full;
  assign w_accept           = duty_if.duty_valid && ~r_pend_full;
  assign w_load             = i_boundary && r_pend_full;
  assign o_active           = r_active;

  // Accept and consume cannot coincide: accepting requires an empty slot,
  // consuming requires a full one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending   <= '0;
      r_pend_full <= 1'b0;
    end else if (w_accept) begin
      r_pending   <= duty_if.duty;
      r_pend_full <= 1'b1;
    end else if (w_load) begin
      r_pend_full <= 1'b0;
    end
  end

`ifdef SOFT_START_EN
  logic [CW-1:0] r_target;
  logic [CW-1:0] w_target_now;
  logic [CW:0]   w_sum;
  logic [CW-1:0] w_ramp;

  // A duty consumed at this boundary is already the target for this step.
  assign w_target_now = w_load ? r_pending : r_target;
  assign w_sum        = {1'b0, r_active} + (CW+1)'(RAMP_STEP);

  always_comb begin
    w_ramp = w_target_now;
    if ((w_target_now > r_active) && (w_sum < {1'b0, w_target_now})) begin
      w_ramp = w_sum[CW-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_target <= '0;
      r_active <= '0;
    end else begin
      if (w_load) begin
        r_target <= r_pending;
      end
      if (!i_run) begin
        r_active <= '0;
      end else if (i_boundary) begin
        r_active <= w_ramp;
      end
    end
  end
`else
  logic w_unused_ramp;
  assign w_unused_ramp = ^{i_run, 32'(RAMP_STEP)};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_active <= '0;
    end else if (w_load) begin
      r_active <= r_pending;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/motor_pwm_driver.sv
// ============================================================================
// Module      : motor_pwm_driver
// Description : Drives one rover motor H-bridge from the shared up-counter.
//               PWM = count < active duty, direction changes go through a
//               whole-period dead-time window with PWM forced low.
// Ports       : clock, reset   - 100 MHz clock, synchronous active-high reset
//               enable         - 1 drive motor, 0 coast
//               counterPeriod  - period programmed into the upstream counter
//               countedUpTo    - live count, 0..counterPeriod-1
//               duty_if        - duty handshake (slave side)
//               dir_req        - requested direction (1 = forward)
//               pwm_out        - registered PWM to the bridge enable
//               dir_out        - registered direction to the bridge
//               period_tick    - pulse on the first output cycle of a period
//               busy           - high while in dead time
// Options     : SOFT_START_EN - duty ramp-up (see pwm_duty_shadow)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module motor_pwm_driver
  import rover_pwm_pkg::*;
#(
  parameter int CW           = CW_DEFAULT,
  parameter int DEAD_PERIODS = 2,
  parameter int RAMP_STEP    = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [CW-1:0]     counterPeriod,
  input  logic [CW-1:0]     countedUpTo,
  motor_pwm_driver_if.slave duty_if,
  input  logic              dir_req,
  output logic              pwm_out,
  output logic              dir_out,
  output logic              period_tick,
  output logic              busy
);

  localparam int            DW          = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [DW-1:0] c_DEAD_LAST = DW'(DEAD_PERIODS - 1);

  state_t        r_state;
  state_t        w_state_n;
  logic [DW-1:0] r_dead_cnt;
  logic [DW-1:0] w_dead_n;
  logic          r_dir;
  logic          w_dir_n;
  logic          r_pwm;
  logic          r_wrap_d;
  logic          r_tick;
  logic [CW-1:0] w_last;
  logic          w_wrap;
  logic [CW-1:0] w_active;

  // The boundary is the last count of a period: everything that changes
  // "at a boundary" lands in registers exactly as count 0 is presented, so
  // the first output cycle of the new period already uses the new state and
  // duty. period_tick (two stages later) lines up with that output cycle.
  assign w_last = (counterPeriod != '0) ? (counterPeriod - CW'(1)) : '0;
  assign w_wrap = (counterPeriod != '0) && (countedUpTo == w_last);

  pwm_duty_shadow #(
    .CW        (CW),
    .RAMP_STEP (RAMP_STEP)
  ) u_shadow (
    .clock      (clock),
    .reset      (reset),
    .i_boundary (w_wrap),
    .i_run      (r_state == RUN),
    .duty_if    (duty_if),
    .o_active   (w_active)
  );

  always_comb begin
    w_state_n = r_state;
    w_dead_n  = r_dead_cnt;
    w_dir_n   = r_dir;
    if (!enable) begin
      w_state_n = STOP;
    end else begin
      case (r_state)
        STOP: begin
          if (w_wrap) begin
            w_state_n = RUN;
          end
        end
        RUN: begin
          if (dir_req != r_dir) begin
            w_state_n = DEAD;
            w_dead_n  = '0;
          end
        end
        DEAD: begin
          // dir_req is only sampled on exit, so a request that reverts
          // mid-window still serves the full dead time.
          if (w_wrap) begin
            if (r_dead_cnt == c_DEAD_LAST) begin
              w_state_n = RUN;
              w_dir_n   = dir_req;
            end else begin
              w_dead_n = r_dead_cnt + DW'(1);
            end
          end
        end
        default: w_state_n = STOP;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= STOP;
      r_dead_cnt <= '0;
      r_dir      <= 1'b1;
      r_pwm      <= 1'b0;
      r_wrap_d   <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_dead_cnt <= w_dead_n;
      r_dir      <= w_dir_n;
      r_wrap_d   <= w_wrap;
      r_tick     <= r_wrap_d;
      // Requiring RUN now and next gives an immediate low on stop/reversal
      // and keeps the start aligned to the first count of a period.
      r_pwm      <= (r_state == RUN) && (w_state_n == RUN) &&
                    (counterPeriod != '0) && (countedUpTo < w_active);
    end
  end

  assign pwm_out     = r_pwm;
  assign dir_out     = r_dir;
  assign period_tick = r_tick;
  assign busy        = (r_state == DEAD);

endmodule

`default_nettype wire

// File: tb/tb_motor_pwm_driver.sv
`timescale 1ns/1ps
`default_nettype none

module tb_motor_pwm_driver;

  localparam int CW = 28;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          dir_req = 1'b1;
  logic [CW-1:0] counterPeriod = '0;
  logic [CW-1:0] countedUpTo = '0;
  logic          pwm_out;
  logic          dir_out;
  logic          period_tick;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  motor_pwm_driver_if #(.CW(CW)) u_if ();

  motor_pwm_driver #(
    .CW           (CW),
    .DEAD_PERIODS (2),
    .RAMP_STEP    (64)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .counterPeriod (counterPeriod),
    .countedUpTo   (countedUpTo),
    .duty_if       (u_if),
    .dir_req       (dir_req),
    .pwm_out       (pwm_out),
    .dir_out       (dir_out),
    .period_tick   (period_tick),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Upstream counter model: 0..counterPeriod-1, held at 0 when period is 0.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (counterPeriod == '0)                      countedUpTo = '0;
      else if (countedUpTo >= counterPeriod - 28'd1) countedUpTo = '0;
      else                                          countedUpTo = countedUpTo + 28'd1;
    end
  end

  task automatic send_duty(input logic [CW-1:0] v);
    int k;
    @(negedge clock);
    u_if.duty       = v;
    u_if.duty_valid = 1'b1;
    for (k = 0; k < 500 && u_if.duty_ready !== 1'b1; k++) @(negedge clock);
    n_checks++;
    if (u_if.duty_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_duty_timeout: duty_ready=%b, required 1", u_if.duty_ready);
    end
    @(posedge clock);
    #1;
    u_if.duty_valid = 1'b0;
  endtask

  task automatic wait_tick();
    bit found = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (period_tick === 1'b1) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_tick_timeout: no period_tick in 3000 cycles, required one");
    end
  endtask

  // Starts on a tick cycle; ends on the following tick cycle.
  task automatic measure(input int p, output int highs, output int shape_err, output int tick_err);
    bit seen_low = 0;
    highs = 0; shape_err = 0; tick_err = 0;
    for (int i = 0; i < p; i++) begin
      if (i > 0) @(negedge clock);
      if (pwm_out === 1'b1) begin
        highs++;
        if (seen_low) shape_err++;
      end else begin
        seen_low = 1;
      end
      if (period_tick !== (i == 0)) tick_err++;
    end
    @(negedge clock);
    if (period_tick !== 1'b1) tick_err++;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; dir_req = 1'b1; counterPeriod = 28'd100;
    u_if.duty = '0; u_if.duty_valid = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (pwm_out !== 1'b0)     begin n_fail++; $display("FAIL reset_pwm: got %b, required 0", pwm_out); end
    n_checks++; if (dir_out !== 1'b1)     begin n_fail++; $display("FAIL reset_dir: got %b, required 1", dir_out); end
    n_checks++; if (period_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b, required 0", period_tick); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if (u_if.duty_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", u_if.duty_ready); end
    reset = 1'b0;
  endtask

  task automatic test_basic_pwm();
    int h, s, t;
    send_duty(28'd25);
    enable = 1'b1;
    wait_tick();
    measure(100, h, s, t);
    n_checks++; if (h != 25) begin n_fail++; $display("FAIL basic_high_count: got %0d, required 25", h); end
    n_checks++; if (s != 0)  begin n_fail++; $display("FAIL basic_shape: got %0d late highs, required 0", s); end
    n_checks++; if (t != 0)  begin n_fail++; $display("FAIL basic_tick: got %0d tick errors, required 0", t); end
  endtask

  task automatic test_duty_extremes();
    int h, s, t;
    send_duty(28'd0);
    wait_tick();
    measure(100, h, s, t);
    n_checks++; if (h != 0) begin n_fail++; $display("FAIL zero_duty_high: got %0d, required 0", h); end
    n_checks++; if (t != 0) begin n_fail++; $display("FAIL zero_duty_tick: got %0d tick errors, required 0", t); end
    send_duty(28'd150);
    wait_tick();
    for (int r = 0; r < 2; r++) begin
      measure(100, h, s, t);
      n_checks++; if (h != 100) begin n_fail++; $display("FAIL full_duty_high[%0d]: got %0d, required 100", r, h); end
      n_checks++; if (t != 0)   begin n_fail++; $display("FAIL full_duty_tick[%0d]: got %0d tick errors, required 0", r, t); end
    end
  endtask

  task automatic test_back_to_back();
    int h, s, t;
    send_duty(28'd10);
    @(negedge clock);
    u_if.duty = 28'd40; u_if.duty_valid = 1'b1;
    n_checks++; if (u_if.duty_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_blocked: got %b, required 0", u_if.duty_ready); end
    wait_tick();
    u_if.duty_valid = 1'b0;
    // 40 was taken on the first count of this period, so the slot is full again.
    n_checks++; if (u_if.duty_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_taken: got %b, required 0", u_if.duty_ready); end
    measure(100, h, s, t);
    n_checks++; if (h != 10) begin n_fail++; $display("FAIL b2b_first_duty: got %0d, required 10", h); end
    measure(100, h, s, t);
    n_checks++; if (h != 40) begin n_fail++; $display("FAIL b2b_second_duty: got %0d, required 40", h); end
  endtask

  task automatic test_direction();
    int busy_cnt = 0, hi_cnt = 0, h, s, t;
    logic dir_before = 1'bx, dir_after = 1'bx;
    dir_req = 1'b0;                      // at a tick cycle, running forward
    for (int i = 1; i <= 199; i++) begin
      @(negedge clock);
      if (busy === 1'b1)    busy_cnt++;
      if (pwm_out === 1'b1) hi_cnt++;
      if (i == 198) dir_before = dir_out;
      if (i == 199) dir_after  = dir_out;
    end
    n_checks++; if (busy_cnt != 198) begin n_fail++; $display("FAIL dir_busy_cycles: got %0d, required 198", busy_cnt); end
    n_checks++; if (hi_cnt != 0)     begin n_fail++; $display("FAIL dir_pwm_in_dead: got %0d highs, required 0", hi_cnt); end
    n_checks++; if (dir_before !== 1'b1) begin n_fail++; $display("FAIL dir_held: got %b, required 1", dir_before); end
    n_checks++; if (dir_after !== 1'b0)  begin n_fail++; $display("FAIL dir_flipped: got %b, required 0", dir_after); end
    @(negedge clock);
    n_checks++; if (period_tick !== 1'b1) begin n_fail++; $display("FAIL dir_resume_tick: got %b, required 1", period_tick); end
    measure(100, h, s, t);
    n_checks++; if (h != 40) begin n_fail++; $display("FAIL dir_resume_duty: got %0d, required 40", h); end
  endtask

  task automatic test_enable();
    int hi_cnt = 0;
    enable = 1'b0;                       // at a tick cycle with pwm high
    @(negedge clock);
    n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL stop_pwm_low: got %b, required 0", pwm_out); end
    enable = 1'b1;
    for (int i = 2; i <= 99; i++) begin
      @(negedge clock);
      if (pwm_out === 1'b1) hi_cnt++;
    end
    n_checks++; if (hi_cnt != 0) begin n_fail++; $display("FAIL restart_early: got %0d highs, required 0", hi_cnt); end
    @(negedge clock);
    n_checks++; if ({period_tick, pwm_out} !== 2'b11) begin n_fail++; $display("FAIL restart_aligned: got tick/pwm %b, required 11", {period_tick, pwm_out}); end
  endtask

  task automatic test_reset_mid();
    int h, s, t, ticks = 0, hi_cnt = 0;
    u_if.duty = 28'd77; u_if.duty_valid = 1'b1;
    reset = 1'b1;                        // pwm high here, dir_out reversed
    @(negedge clock);
    n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL midreset_pwm: got %b, required 0", pwm_out); end
    n_checks++; if (dir_out !== 1'b1) begin n_fail++; $display("FAIL midreset_dir: got %b, required 1", dir_out); end
    n_checks++; if (u_if.duty_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b, required 1", u_if.duty_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b, required 0", busy); end
    u_if.duty_valid = 1'b0; dir_req = 1'b1; reset = 1'b0;
    wait_tick();
    measure(100, h, s, t);
    n_checks++; if (h != 0) begin n_fail++; $display("FAIL midreset_no_duty: got %0d highs, required 0", h); end
    counterPeriod = '0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (period_tick === 1'b1) ticks++;
      if (pwm_out === 1'b1)     hi_cnt++;
    end
    n_checks++; if (ticks != 0)  begin n_fail++; $display("FAIL zero_period_ticks: got %0d, required 0", ticks); end
    n_checks++; if (hi_cnt != 0) begin n_fail++; $display("FAIL zero_period_pwm: got %0d highs, required 0", hi_cnt); end
  endtask

  task automatic test_soft_start();
    int h, s, t;
    int exp_h [5] = '{0, 64, 128, 192, 200};
    counterPeriod = 28'd1000;
    send_duty(28'd200);
    enable = 1'b1;
    wait_tick();
    for (int r = 0; r < 5; r++) begin
      measure(1000, h, s, t);
      n_checks++; if (h != exp_h[r]) begin n_fail++; $display("FAIL ramp_step[%0d]: got %0d, required %0d", r, h, exp_h[r]); end
    end
  endtask

  initial begin
    test_reset();
`ifdef SOFT_START_EN
    test_soft_start();
`else
    test_basic_pwm();
    test_duty_extremes();
    test_back_to_back();
    test_direction();
    test_enable();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
